// File: rtl/moore_pkg.sv
// Shared definitions for the Moore serial pattern detector: state encodings
// and the pattern-width legality check.
package moore_pkg;

    localparam logic [1:0] FILL  = 2'b00;
    localparam logic [1:0] HUNT  = 2'b01;
    localparam logic [1:0] MATCH = 2'b10;

    typedef enum logic [1:0] {
        S_FILL    = FILL,
        S_HUNT    = HUNT,
        S_MATCH   = MATCH,
        S_ILLEGAL = 2'b11
    } state_e;

    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 16;

    function automatic bit pat_w_legal(input int unsigned w);
        return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear that coincides with an increment restarts the count at one.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector: shifts x_in into a PAT_W-bit history and
// flags a match against a run-time pattern, with optional overlap.
module moore_seq_detector
    import moore_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             match,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
        $error("moore_seq_detector: PAT_W out of range 2..16");
    end

    state_e            r_state;
    state_e            w_state_n;
    logic [PAT_W-1:0]  r_hist;
    logic [PAT_W-1:0]  w_hist_n;
    logic [FILL_W-1:0] r_fill;
    logic [FILL_W-1:0] w_fill_n;
    logic              r_match;

    logic [PAT_W-1:0]  w_hist_sh;
    logic [FILL_W-1:0] w_fill_inc;
    logic              w_full;
    logic              w_hit;
    logic              w_cnt_inc;

    // Candidate history/fill if this edge consumes a bit.
    assign w_hist_sh  = {r_hist[PAT_W-2:0], x_in};
    assign w_fill_inc = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
    assign w_full     = (w_fill_inc == FILL_FULL);
    assign w_hit      = en && w_full && (w_hist_sh == pattern);

    // Next-state, history and fill decode.
    always_comb begin
        w_state_n = r_state;
        w_hist_n  = r_hist;
        w_fill_n  = r_fill;
        w_cnt_inc = 1'b0;

        if (r_state == S_ILLEGAL) begin
            w_state_n = S_FILL;
            w_fill_n  = '0;
        end else if (en) begin
            w_hist_n = w_hist_sh;
            if (w_hit) begin
                w_state_n = S_MATCH;
                w_cnt_inc = 1'b1;
                w_fill_n  = overlap ? w_fill_inc : '0;
            end else if (w_full) begin
                w_state_n = S_HUNT;
                w_fill_n  = w_fill_inc;
            end else begin
                w_state_n = S_FILL;
                w_fill_n  = w_fill_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_hist  <= w_hist_n;
            r_fill  <= w_fill_n;
            r_match <= (w_state_n == S_MATCH);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_cnt_inc),
        .clr (clr_cnt),
        .cnt (match_cnt)
    );

    assign match     = r_match;
    assign state_out = r_state;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: a vector table on a PAT_W=4/CNT_W=8
// instance plus hand sequences on a CNT_W=2 instance for saturation/clear.
module tb_moore_seq_detector;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: pattern 1011, CNT_W=8
    logic       rst_a, en_a, x_a, ov_a, clr_a;
    logic [3:0] pat_a;
    logic       match_a;
    logic [1:0] state_a;
    logic [7:0] cnt_a;

    // Instance B: pattern 1111, CNT_W=2
    logic       rst_b, en_b, x_b, ov_b, clr_b;
    logic [3:0] pat_b;
    logic       match_b;
    logic [1:0] state_b;
    logic [1:0] cnt_b;

    moore_seq_detector #(.PAT_W(4), .CNT_W(8)) u_dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .en        (en_a),
        .x_in      (x_a),
        .pattern   (pat_a),
        .overlap   (ov_a),
        .clr_cnt   (clr_a),
        .match     (match_a),
        .state_out (state_a),
        .match_cnt (cnt_a)
    );

    moore_seq_detector #(.PAT_W(4), .CNT_W(2)) u_dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .en        (en_b),
        .x_in      (x_b),
        .pattern   (pat_b),
        .overlap   (ov_b),
        .clr_cnt   (clr_b),
        .match     (match_b),
        .state_out (state_b),
        .match_cnt (cnt_b)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       x;
        logic       ov;
        logic       clr;
        logic       exp_match;
        logic [1:0] exp_state;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic x, input logic ov,
                       input logic clr, input logic em, input logic [1:0] es,
                       input logic [7:0] ec);
        vec_t v;
        v.rst = r; v.en = e; v.x = x; v.ov = ov; v.clr = clr;
        v.exp_match = em; v.exp_state = es; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    // One stimulus cycle on instance B followed by a check after the edge.
    task automatic step_b(input string tag, input logic r, input logic e, input logic x,
                          input logic clr, input logic em, input logic [1:0] es,
                          input logic [1:0] ec);
        @(negedge clk);
        rst_b = r; en_b = e; x_b = x; clr_b = clr;
        @(posedge clk);
        #1;
        chk({tag, ".match"}, 32'(match_b), 32'(em));
        chk({tag, ".state"}, 32'(state_b), 32'(es));
        chk({tag, ".cnt"},   32'(cnt_b),   32'(ec));
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; x_a = 1'b0; ov_a = 1'b1; clr_a = 1'b0; pat_a = 4'b1011;
        rst_b = 1'b1; en_b = 1'b0; x_b = 1'b0; ov_b = 1'b1; clr_b = 1'b0; pat_b = 4'b1111;

        // Reset for two cycles, then 1,0,1 stays in FILL; 1 hits; 0 -> HUNT
        add(1,0,0,1,0, 0,2'b00,0);
        add(1,1,1,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 0,2'b00,0);
        add(0,1,0,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 1,2'b10,1);
        add(0,1,0,1,0, 0,2'b01,1);
        // Overlap: 1,0,1,1,0,1,1 -> hits after bits 4 and 7
        add(1,0,0,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 0,2'b00,0);
        add(0,1,0,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 1,2'b10,1);
        add(0,1,0,1,0, 0,2'b01,1);
        add(0,1,1,1,0, 0,2'b01,1);
        add(0,1,1,1,0, 1,2'b10,2);
        // Non-overlap: same stream, only the first hit; FILL after bit 7
        add(1,0,0,0,0, 0,2'b00,0);
        add(0,1,1,0,0, 0,2'b00,0);
        add(0,1,0,0,0, 0,2'b00,0);
        add(0,1,1,0,0, 0,2'b00,0);
        add(0,1,1,0,0, 1,2'b10,1);
        add(0,1,0,0,0, 0,2'b00,1);
        add(0,1,1,0,0, 0,2'b00,1);
        add(0,1,1,0,0, 0,2'b00,1);
        // Enable gating: 3-cycle gaps with x toggling, match held in trailing gap
        add(1,0,0,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 0,2'b00,0);
        add(0,0,0,1,0, 0,2'b00,0);
        add(0,0,1,1,0, 0,2'b00,0);
        add(0,0,0,1,0, 0,2'b00,0);
        add(0,1,0,1,0, 0,2'b00,0);
        add(0,0,1,1,0, 0,2'b00,0);
        add(0,0,0,1,0, 0,2'b00,0);
        add(0,0,1,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 0,2'b00,0);
        add(0,0,0,1,0, 0,2'b00,0);
        add(0,0,1,1,0, 0,2'b00,0);
        add(0,0,0,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 1,2'b10,1);
        add(0,0,0,1,0, 1,2'b10,1);
        add(0,0,1,1,0, 1,2'b10,1);
        add(0,0,0,1,0, 1,2'b10,1);
        // Clear alone while holding: count drops, match stays
        add(0,0,1,1,1, 1,2'b10,0);
        add(0,1,0,1,0, 0,2'b01,0);
        // Reset mid-operation discards partial history
        add(1,0,0,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 0,2'b00,0);
        add(0,1,0,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 0,2'b00,0);
        add(1,1,1,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 0,2'b00,0);
        add(0,1,0,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 0,2'b00,0);
        add(0,1,1,1,0, 1,2'b10,1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_a = vecs[i].rst; en_a = vecs[i].en; x_a = vecs[i].x;
            ov_a = vecs[i].ov; clr_a = vecs[i].clr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.match", i), 32'(match_a), 32'(vecs[i].exp_match));
            chk($sformatf("vec%0d.state", i), 32'(state_a), 32'(vecs[i].exp_state));
            chk($sformatf("vec%0d.cnt", i),   32'(cnt_a),   32'(vecs[i].exp_cnt));
        end

        // Saturation on CNT_W=2: pattern 1111, seven ones -> 4 hits, count 3
        step_b("sat_rst", 1, 0, 0, 0, 0, 2'b00, 2'd0);
        step_b("sat_b1",  0, 1, 1, 0, 0, 2'b00, 2'd0);
        step_b("sat_b2",  0, 1, 1, 0, 0, 2'b00, 2'd0);
        step_b("sat_b3",  0, 1, 1, 0, 0, 2'b00, 2'd0);
        step_b("sat_b4",  0, 1, 1, 0, 1, 2'b10, 2'd1);
        step_b("sat_b5",  0, 1, 1, 0, 1, 2'b10, 2'd2);
        step_b("sat_b6",  0, 1, 1, 0, 1, 2'b10, 2'd3);
        step_b("sat_b7",  0, 1, 1, 0, 1, 2'b10, 2'd3);
        // Clear coinciding with a hit restarts at one
        step_b("clr_hit", 0, 1, 1, 1, 1, 2'b10, 2'd1);
        step_b("clr_only",0, 0, 1, 1, 1, 2'b10, 2'd0);

        // Pattern change while idle never alters match retroactively
        @(negedge clk);
        pat_b = 4'b0000;
        step_b("pat_hold", 0, 0, 0, 0, 1, 2'b10, 2'd0);
        step_b("pat_new",  0, 1, 1, 0, 0, 2'b01, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
